uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive buffer sitting directly downstream of the UART receiver. It captures each completed byte on the receiver's one-cycle done pulse and holds it in a circular register-array queue until the host side reads it. It reports occupancy, full/empty and almost-full status, and keeps a sticky overrun flag when a byte arrives with no free slot.

## Interface
Parameters:
- D_BIT, 8, data word width; must match the receiver's D_BIT.
- ADDR_W, 4, address width; depth = 2^ADDR_W entries (16 by default).
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL; legal range 1..2^ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr  input  1  write strobe; connected to the receiver's rx_done_tick. One cycle per byte.
- w_data  input  D_BIT  byte to store; connected to the receiver's data output. Sampled when wr=1.
- rd  input  1  pop strobe from the consumer.
- r_data  output  D_BIT  head-of-queue word, first-word-fall-through.
- empty  output  1  queue holds 0 entries.
- full  output  1  queue holds 2^ADDR_W entries.
- count  output  ADDR_W+1  current number of entries, 0..2^ADDR_W.
- almost_full  output  1  count >= AF_LEVEL.
- overrun  output  1  sticky flag; a write was dropped because the queue was full.
- clr_ovr  input  1  synchronous clear of overrun.

## Operation
- Storage: 2^ADDR_W x D_BIT register array, not reset. Write pointer w_ptr and read pointer r_ptr are ADDR_W bits wide and wrap modulo 2^ADDR_W. A registered count of ADDR_W+1 bits holds occupancy.
- Flags derive only from count: empty = (count==0), full = (count==2^ADDR_W), almost_full = (count>=AF_LEVEL). These are combinational from registers, with no extra latency.
- r_data = mem[r_ptr] combinationally. It is valid only while empty=0; its value while empty=1 is unspecified.
- Effective write: we = wr & (~full | rd_eff). Effective read: rd_eff = rd & ~empty.
- On we: mem[w_ptr] <= w_data, w_ptr <= w_ptr+1.
- On rd_eff: r_ptr <= r_ptr+1.
- count update: +1 if we & ~rd_eff; -1 if rd_eff & ~we; otherwise unchanged.
- Boundary cases:
  - Full with wr and rd in the same cycle: both accepted, count stays 2^ADDR_W, and overrun is not set.
  - Empty with wr and rd in the same cycle: rd is ignored, the write is accepted, and count becomes 1.
  - rd while empty: no effect and no error flag.
  - wr while full without rd: the byte is dropped, pointers and count are unchanged, and overrun is set.
- overrun: set on any dropped write; cleared by clr_ovr. If a drop and clr_ovr happen in the same cycle, set wins.
- Reset (rst=0, asynchronous): w_ptr=0, r_ptr=0, count=0, overrun=0. As a result, empty=1, full=0, almost_full=0. Reset mid-operation discards all queued data immediately, without waiting for a clock edge.

## Timing
- Write-to-visible latency is 1 cycle. After the edge where wr=1 into an empty queue, empty=0 and r_data=w_data.
- Pop is 1 cycle. After the edge with rd_eff=1, r_data shows the next entry, or empty=1 if none remain.
- wr may be asserted on consecutive cycles. The block accepts one word per cycle, which is well above the UART byte rate.
- Deassertion of rst is synchronised externally. The block has no requirement beyond the first edge after release.

## Test plan
- Reset and single byte: hold rst=0 and check empty=1, full=0, count=0, overrun=0. Release, pulse wr with 0xA5. Next cycle: empty=0, count=1, r_data=0xA5. Pulse rd; next cycle: empty=1, count=0.
- Fill and order, with depth 16: write 0x00..0x0F on consecutive cycles. Check that almost_full asserts when count reaches 12 and that full=1 with count=16 after the last write. Then read 16 times and check r_data sequence 0x00..0x0F, then empty=1.
- Overrun: with the queue full, pulse wr with 0xFF. Check count=16, overrun=1, and that contents are unchanged (reads return 0x00..0x0F). Assert clr_ovr and check overrun=0. Assert clr_ovr together with another dropped write and check overrun=1.
- Simultaneous operations:
  - When full: wr=0x55 with rd gives count=16, overrun=0, and 0x55 is read last.
  - When empty: wr=0x3C with rd gives count=1 and r_data=0x3C.
  - rd alone when empty: count stays 0.
- Wrap-around: perform 40 write/read pairs with interleaved occupancy of 0..5, so the pointers wrap at least twice. Check that the data order matches a reference queue and that count never mismatches.
- Reset mid-operation: with count=7, drive rst=0 between clock edges. Check immediately that count=0, empty=1 and overrun=0. After release, write 0x11 and check r_data=0x11.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART receiver: captures bytes on the done pulse,
// presents the head word first-word-fall-through, and tracks occupancy and overrun.
module uart_rx_fifo #(
  parameter int D_BIT    = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [D_BIT-1:0]  i_w_data,
  input  logic              i_rd,
  input  logic              i_clr_ovr,
  output logic [D_BIT-1:0]  o_r_data,
  output logic              o_empty,
  output logic              o_full,
  output logic [ADDR_W:0]   o_count,
  output logic              o_almost_full,
  output logic              o_overrun
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] C_AF    = (ADDR_W+1)'(AF_LEVEL);

  logic [D_BIT-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_w_ptr;
  logic [ADDR_W-1:0] r_r_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overrun;

  logic w_empty;
  logic w_full;
  logic w_rd_eff;
  logic w_we;
  logic w_drop;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == C_DEPTH);
  assign w_rd_eff = i_rd & ~w_empty;
  // A pop in the same cycle frees the slot, so a write into a full queue still lands.
  assign w_we     = i_wr & (~w_full | w_rd_eff);
  assign w_drop   = i_wr & ~w_we;

  // Storage carries no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_we) begin
      r_mem[r_w_ptr] <= i_w_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_w_ptr   <= '0;
      r_r_ptr   <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_we) begin
        r_w_ptr <= r_w_ptr + 1'b1;
      end
      if (w_rd_eff) begin
        r_r_ptr <= r_r_ptr + 1'b1;
      end
      case ({w_we, w_rd_eff})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear must remain visible.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_clr_ovr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign o_r_data      = r_mem[r_r_ptr];
  assign o_empty       = w_empty;
  assign o_full        = w_full;
  assign o_count       = r_count;
  assign o_almost_full = (r_count >= C_AF);
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, hand sequences for the
// full/overrun/reset corners, and randomized traffic against a queue model.
module tb_uart_rx_fifo;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_wr;
  logic [7:0] i_w_data;
  logic       i_rd;
  logic       i_clr_ovr;
  logic [7:0] o_r_data;
  logic       o_empty;
  logic       o_full;
  logic [4:0] o_count;
  logic       o_almost_full;
  logic       o_overrun;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo #(.D_BIT(8), .ADDR_W(4), .AF_LEVEL(12)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_wr          (i_wr),
    .i_w_data      (i_w_data),
    .i_rd          (i_rd),
    .i_clr_ovr     (i_clr_ovr),
    .o_r_data      (o_r_data),
    .o_empty       (o_empty),
    .o_full        (o_full),
    .o_count       (o_count),
    .o_almost_full (o_almost_full),
    .o_overrun     (o_overrun)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    string    name;
    bit       wr;
    bit [7:0] data;
    bit       rd;
    bit       clr;
    int       cnt;
    bit       emp;
    bit       ful;
    bit       af;
    bit       ovr;
    bit       chk_data;
    bit [7:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input int cnt, input bit emp,
                             input bit ful, input bit af, input bit ovr);
    check({name, ".count"}, int'(o_count), cnt);
    check({name, ".empty"}, int'(o_empty), int'(emp));
    check({name, ".full"}, int'(o_full), int'(ful));
    check({name, ".almost_full"}, int'(o_almost_full), int'(af));
    check({name, ".overrun"}, int'(o_overrun), int'(ovr));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input bit wr, input bit [7:0] d, input bit rd, input bit clr);
    @(negedge i_clk);
    i_wr = wr; i_w_data = d; i_rd = rd; i_clr_ovr = clr;
    @(posedge i_clk);
    #1;
    i_wr = 1'b0; i_rd = 1'b0; i_clr_ovr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic add_vec(input string n, input bit wr, input bit [7:0] d, input bit rd,
                         input bit clr, input int cnt, input bit emp, input bit ful,
                         input bit af, input bit ovr, input bit cd, input bit [7:0] rdat);
    vec_t v;
    v.name = n; v.wr = wr; v.data = d; v.rd = rd; v.clr = clr; v.cnt = cnt;
    v.emp = emp; v.ful = ful; v.af = af; v.ovr = ovr; v.chk_data = cd; v.rdata = rdat;
    vecs.push_back(v);
  endtask

  logic [7:0] q[$];
  bit         m_ovr;

  task automatic rand_phase(input int cycles, input int pw, input int pr, input int pc);
    bit wr, rd, clr, rd_eff, acc;
    bit [7:0] d;
    for (int n = 0; n < cycles; n++) begin
      wr  = ($urandom_range(0, 99) < pw);
      rd  = ($urandom_range(0, 99) < pr);
      clr = ($urandom_range(0, 99) < pc);
      d   = 8'($urandom);
      rd_eff = rd && (q.size() > 0);
      acc    = wr && ((q.size() < 16) || rd_eff);
      step(wr, d, rd, clr);
      if (rd_eff) void'(q.pop_front());
      if (acc) q.push_back(d);
      if (wr && !acc) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
      check_state("rand", q.size(), q.size() == 0, q.size() == 16, q.size() >= 12, m_ovr);
      if (q.size() > 0) check("rand.r_data", int'(o_r_data), int'(q[0]));
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_wr = 1'b0; i_w_data = 8'h00; i_rd = 1'b0; i_clr_ovr = 1'b0;

    // Directed single-byte and empty-queue corners.
    add_vec("wr_a5",      1, 8'hA5, 0, 0, 1, 0, 0, 0, 0, 1, 8'hA5);
    add_vec("rd_a5",      0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    add_vec("rd_empty",   0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    add_vec("wr_rd_empty",1, 8'h3C, 1, 0, 1, 0, 0, 0, 0, 1, 8'h3C);
    add_vec("clr_idle",   0, 8'h00, 0, 1, 1, 0, 0, 0, 0, 1, 8'h3C);
    add_vec("rd_3c",      0, 8'h00, 1, 0, 0, 1, 0, 0, 0, 0, 8'h00);

    repeat (2) @(negedge i_clk);
    #1;
    check_state("reset", 0, 1, 0, 0, 0);
    i_rst_n = 1'b1;

    foreach (vecs[k]) begin
      step(vecs[k].wr, vecs[k].data, vecs[k].rd, vecs[k].clr);
      check_state(vecs[k].name, vecs[k].cnt, vecs[k].emp, vecs[k].ful, vecs[k].af, vecs[k].ovr);
      if (vecs[k].chk_data) check({vecs[k].name, ".r_data"}, int'(o_r_data), int'(vecs[k].rdata));
    end

    // Fill 0x00..0x0F, watching almost_full and full.
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0);
      check_state("fill", i + 1, 0, i == 15, i + 1 >= 12, 0);
    end
    for (int i = 0; i < 16; i++) begin
      check("drain.r_data", int'(o_r_data), i);
      step(0, 8'h00, 1, 0);
    end
    check_state("drained", 0, 1, 0, 0, 0);

    // Overrun: drop, clear, then drop racing with clear.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hFF, 0, 0);
    check_state("drop_ff", 16, 0, 1, 1, 1);
    check("drop_ff.r_data", int'(o_r_data), 0);
    step(0, 8'h00, 0, 1);
    check_state("clr_ovr", 16, 0, 1, 1, 0);
    step(1, 8'hEE, 0, 1);
    check_state("drop_and_clr", 16, 0, 1, 1, 1);
    step(0, 8'h00, 0, 1);
    check_state("clr_again", 16, 0, 1, 1, 0);

    // Full with simultaneous write and read: 0x55 enters at the tail.
    step(1, 8'h55, 1, 0);
    check_state("wr_rd_full", 16, 0, 1, 1, 0);
    for (int i = 1; i < 16; i++) begin
      check("after_full.r_data", int'(o_r_data), i);
      step(0, 8'h00, 1, 0);
    end
    check("last.r_data", int'(o_r_data), 8'h55);
    step(0, 8'h00, 1, 0);
    check_state("after_full_empty", 0, 1, 0, 0, 0);

    // Randomized traffic: low occupancy with pointer wraps, then heavy writes with overruns.
    q.delete();
    m_ovr = 1'b0;
    rand_phase(200, 50, 50, 5);
    rand_phase(300, 70, 30, 10);
    rand_phase(200, 30, 70, 10);

    // Reset between edges with 7 entries queued.
    do_reset();
    for (int i = 0; i < 7; i++) step(1, 8'(8'h40 + i), 0, 0);
    check_state("pre_reset", 7, 0, 0, 0, 0);
    @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_state("async_reset", 0, 1, 0, 0, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(1, 8'h11, 0, 0);
    check_state("post_reset", 1, 0, 0, 0, 0);
    check("post_reset.r_data", int'(o_r_data), 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
